and_arbiter: RTL and testbench
==============================

AND_ARBITER -- requirements
Module: and_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request, held high until granted.
REQ-005 The block SHALL have port a_in, input, 4*WIDTH bits: operand A per requester; requester i uses bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port b_in, input, 4*WIDTH bits: operand B per requester, packed the same way as a_in.
REQ-007 The block SHALL have port gnt, output, 4 bits: one-hot, single-cycle grant; marks the operand capture cycle.
REQ-008 The block SHALL have port out, output, WIDTH bits: bitwise AND of the granted operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out and out_id hold a result.
REQ-010 The block SHALL have port out_id, output, 2 bits: index of the requester that owns the result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port op_count, output, 16 bits, present only under AND_ARB_CNT_EN: number of grants issued.

Function
REQ-013 The block SHALL share one WIDTH-bit bitwise-AND datapath among 4 requesters using round-robin arbitration.
REQ-014 The FSM SHALL have two states:
- IDLE: out_valid=0.
- HOLD: out_valid=1.
REQ-015 A grant SHALL be permitted in a cycle only when the FSM is in IDLE, or in HOLD with out_ready=1.
REQ-016 When a grant is permitted and req!=0, the winner SHALL be the first requester with req high, searching from (last_grant+1) mod 4 upward with wrap.
REQ-017 In the grant cycle, gnt SHALL be high for the winner only, and a_in/b_in of the winner SHALL be registered at the next edge.
REQ-018 At that same edge, out SHALL become a&b of the registered operands, out_id SHALL become the winner index, out_valid SHALL be 1, and last_grant SHALL become the winner index (1-cycle latency from gnt to out_valid).
REQ-019 In HOLD with out_ready=0, out, out_id and out_valid SHALL remain stable, and gnt SHALL be 0.
REQ-020 A transfer occurs when out_valid=1 and out_ready=1; on a transfer with no grant the FSM SHALL go to IDLE, and with a simultaneous grant it SHALL stay in HOLD with the new result (back-to-back throughput of one result per cycle).
REQ-021 If req drops before its grant, that requester SHALL receive no grant and last_grant SHALL be unchanged.
REQ-022 A requester whose req is still high after its grant SHALL be treated as a new request, arbitrated fairly against the others.
REQ-023 out_ready while in IDLE SHALL have no effect.

Reset
REQ-024 While rst=1, regardless of clk, the block SHALL hold gnt=0, out_valid=0, out=0, out_id=0, FSM=IDLE, last_grant=3 and op_count=0.
REQ-025 Reset asserted mid-operation SHALL discard any held result without a transfer.
REQ-026 After reset deasserts, the first grant SHALL go to the lowest-index active requester.

Configuration
REQ-027 The block SHALL support the macro AND_ARB_CNT_EN.
REQ-028 With AND_ARB_CNT_EN defined:
- op_count port SHALL exist.
- op_count SHALL increment by 1 on every cycle with gnt!=0.
- op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-029 With AND_ARB_CNT_EN undefined, the op_count port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-030 The bench SHALL cover these scenarios:
- Single request: req=0001, a0=0xF0, b0=0x3C, out_ready=1 -> gnt=0001 in cycle 1; cycle 2: out_valid=1, out=0x30, out_id=0; cycle 3: out_valid=0.
- All requesting: req=1111 held, out_ready=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; out_id follows one cycle later.
- Back-pressure: req=0110, out_ready=0 -> gnt=0010 once; out/out_id=1 stable with no gnt for 5 cycles; raising out_ready -> gnt=0100 in the transfer cycle, out_id=2 next cycle.
- Reset mid-HOLD: rst pulsed while out_valid=1 -> out_valid=0 immediately (asynchronous); afterwards req=1010 -> first gnt=0010.
- Counter: with AND_ARB_CNT_EN, 65537 grants -> op_count=1; without AND_ARB_CNT_EN -> builds without the op_count port and all other scenarios pass unchanged.

Source files
------------

// File: rtl/and_arbiter.sv
// and_arbiter: four requesters share one WIDTH-bit bitwise-AND datapath.
// Requesters are served round-robin, searching upward from the last grant.
// The winner's operands are captured in its grant cycle. The AND result is
// presented one cycle later with a valid/ready handshake. A new grant may be
// issued in the same cycle that the held result is accepted, which sustains
// one result per cycle.
//
// Optional feature: define AND_ARB_CNT_EN to add the 16-bit op_count output.
// op_count counts issued grants and wraps from 0xFFFF to 0x0000.
module and_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   a_in,
    input  logic [4*WIDTH-1:0]   b_in,
    output logic [3:0]           gnt,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [1:0]           out_id,
    input  logic                 out_ready
`ifdef AND_ARB_CNT_EN
    ,
    output logic [15:0]          op_count
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         last_q;
    logic [1:0]         last_d;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   out_d;
    logic [1:0]         id_q;
    logic [1:0]         id_d;

    logic               grant_ok_s;
    logic               any_req_s;
    logic               fire_s;
    logic [1:0]         win_s;
    logic [3:0]         gnt_s;
    logic [WIDTH-1:0]   a_sel_s;
    logic [WIDTH-1:0]   b_sel_s;

    // Round-robin pick: first active request after 'last', wrapping around.
    // The final probe (offset 4) revisits 'last' itself, so a requester that
    // keeps its request high after a grant wins only when no one else asks.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Arbitration: decide whether a grant may be issued this cycle and to whom.
    always_comb begin
        grant_ok_s = (state_q == ST_IDLE) || out_ready;
        any_req_s  = |req;
        win_s      = rr_pick(req, last_q);
        gnt_s      = 4'b0000;
        if (grant_ok_s && any_req_s) begin
            gnt_s = 4'b0001 << win_s;
        end else begin
            gnt_s = 4'b0000;
        end
        fire_s = |gnt_s;
    end

    // Grant output: forced low during reset so no capture is ever advertised.
    always_comb begin
        gnt = 4'b0000;
        if (rst) begin
            gnt = 4'b0000;
        end else begin
            gnt = gnt_s;
        end
    end

    // Operand select: route the winner's A and B slices to the AND datapath.
    always_comb begin
        a_sel_s = a_in[win_s*WIDTH +: WIDTH];
        b_sel_s = b_in[win_s*WIDTH +: WIDTH];
    end

    // Next-state logic for the IDLE/HOLD controller and the result registers.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        out_d   = out_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                // out_ready has no meaning without a held result.
                if (fire_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A grant in the transfer cycle refills the slot immediately.
                if (fire_s) begin
                    state_d = ST_HOLD;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (fire_s) begin
            out_d  = a_sel_s & b_sel_s;
            id_d   = win_s;
            last_d = win_s;
        end else begin
            out_d  = out_q;
            id_d   = id_q;
            last_d = last_q;
        end
    end

    // State and result registers. Reset drops any held result, and last_grant = 3
    // makes requester 0 the first one searched after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd3;
            out_q   <= {WIDTH{1'b0}};
            id_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            out_q   <= out_d;
            id_q    <= id_d;
        end
    end

    // Result outputs come straight from registers.
    always_comb begin
        out       = out_q;
        out_id    = id_q;
        out_valid = (state_q == ST_HOLD);
    end

`ifdef AND_ARB_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Grant counter next value: one per issued grant, natural 16-bit wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (fire_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Grant counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter output.
    always_comb begin
        op_count = cnt_q;
    end
`endif

endmodule

// File: tb/tb_and_arbiter.sv
// Bench for and_arbiter (WIDTH=8): directed vector table, reset cases,
// randomized traffic against a round-robin reference model, optional counter.
module tb_and_arbiter;

    localparam int WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic [3:0]           req;
    logic [4*WIDTH-1:0]   a_in;
    logic [4*WIDTH-1:0]   b_in;
    logic [3:0]           gnt;
    logic [WIDTH-1:0]     out;
    logic                 out_valid;
    logic [1:0]           out_id;
    logic                 out_ready;
`ifdef AND_ARB_CNT_EN
    logic [15:0]          op_count;
`endif

    and_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .out       (out),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_ready (out_ready)
`ifdef AND_ARB_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt;
    int total_cnt;

    // Reference model state: what the spec says should be held.
    bit          valid_m;
    logic [7:0]  out_m;
    int          id_m;
    int          last_m;
    int          cnt_m;

    typedef struct {
        bit          rb;
        logic [3:0]  rq;
        logic [31:0] a;
        logic [31:0] b;
        bit          rdy;
        logic [3:0]  egnt;
        bit          evalid;
        logic [7:0]  eout;
        logic [1:0]  eid;
    } vec_t;

    vec_t vecs [0:18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input bit rb, input logic [3:0] rq,
                           input logic [31:0] a, input logic [31:0] b, input bit rdy,
                           input logic [3:0] g, input bit v, input logic [7:0] o,
                           input logic [1:0] id);
        vecs[i].rb = rb;    vecs[i].rq = rq;   vecs[i].a = a;      vecs[i].b = b;
        vecs[i].rdy = rdy;  vecs[i].egnt = g;  vecs[i].evalid = v;
        vecs[i].eout = o;   vecs[i].eid = id;
    endtask

    function automatic logic [3:0] model_gnt(input logic [3:0] r, input bit rdy);
        logic [3:0] g;
        int idx;
        g = 4'b0000;
        if ((!valid_m || rdy) && (r != 4'b0000)) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (last_m + k) % 4;
                if (g == 4'b0000 && r[idx]) g = 4'b0001 << idx;
            end
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) if (g[k]) r = k;
        return r;
    endfunction

    task automatic model_reset();
        valid_m = 1'b0;
        out_m   = 8'h00;
        id_m    = 0;
        last_m  = 3;
        cnt_m   = 0;
    endtask

    // Drive one cycle's inputs (called just after a rising edge), then wait to the falling edge.
    task automatic drive_sample(input logic [3:0] rq, input logic [31:0] a,
                                input logic [31:0] b, input bit rdy);
        req = rq; a_in = a; b_in = b; out_ready = rdy;
        @(negedge clk);
    endtask

    // Compare DUT with model at the falling edge, apply the model's edge update, then move past the rising edge.
    task automatic advance(input string tag);
        logic [3:0] eg;
        int w;
        eg = model_gnt(req, out_ready);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".valid"}, 32'(out_valid), 32'(valid_m));
        if (valid_m) begin
            chk({tag, ".out"}, 32'(out), 32'(out_m));
            chk({tag, ".id"}, 32'(out_id), 32'(id_m));
        end
`ifdef AND_ARB_CNT_EN
        chk({tag, ".cnt"}, 32'(op_count), 32'(cnt_m));
`endif
        if (eg != 4'b0000) begin
            w       = onehot_idx(eg);
            out_m   = a_in[w*8 +: 8] & b_in[w*8 +: 8];
            id_m    = w;
            last_m  = w;
            valid_m = 1'b1;
            cnt_m   = (cnt_m + 1) % 65536;
        end else if (valid_m && out_ready) begin
            valid_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset pulse away from the clock edge; gnt must stay low even with requests pending.
    task automatic do_reset();
        rst = 1'b1; req = 4'hF; out_ready = 1'b1;
        #1;
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.valid", 32'(out_valid), 32'h0);
        chk("rst.out", 32'(out), 32'h0);
        chk("rst.id", 32'(out_id), 32'h0);
`ifdef AND_ARB_CNT_EN
        chk("rst.cnt", 32'(op_count), 32'h0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.gnt_clk", 32'(gnt), 32'h0);
        chk("rst.valid_clk", 32'(out_valid), 32'h0);
        rst = 1'b0; req = 4'h0;
        model_reset();
    endtask

    initial begin
        logic [31:0] s1a, s1b, ab_a, ab_b;
        clk = 1'b0; rst = 1'b1; req = 4'h0; a_in = '0; b_in = '0; out_ready = 1'b0;
        pass_cnt = 0; total_cnt = 0;
        model_reset();

        s1a  = 32'h0000_00F0;  s1b  = 32'h0000_003C;
        ab_a = 32'h8844_2211;  ab_b = 32'hFFFF_FFFF;

        // Single request
        set_vec(0,  1'b1, 4'b0001, s1a, s1b, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0);
        set_vec(1,  1'b0, 4'b0000, s1a, s1b, 1'b1, 4'b0000, 1'b1, 8'h30, 2'd0);
        set_vec(2,  1'b0, 4'b0000, s1a, s1b, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
        // All requesting, back-to-back
        set_vec(3,  1'b1, 4'b1111, ab_a, ab_b, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0);
        set_vec(4,  1'b0, 4'b1111, ab_a, ab_b, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd0);
        set_vec(5,  1'b0, 4'b1111, ab_a, ab_b, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd1);
        set_vec(6,  1'b0, 4'b1111, ab_a, ab_b, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd2);
        set_vec(7,  1'b0, 4'b1111, ab_a, ab_b, 1'b1, 4'b0001, 1'b1, 8'h88, 2'd3);
        set_vec(8,  1'b0, 4'b0000, ab_a, ab_b, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd0);
        set_vec(9,  1'b0, 4'b0000, ab_a, ab_b, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
        // Back-pressure
        set_vec(10, 1'b1, 4'b0110, ab_a, ab_b, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd0);
        for (int i = 11; i <= 15; i++)
            set_vec(i, 1'b0, 4'b0100, ab_a, ab_b, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1);
        set_vec(16, 1'b0, 4'b0100, ab_a, ab_b, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd1);
        set_vec(17, 1'b0, 4'b0000, ab_a, ab_b, 1'b1, 4'b0000, 1'b1, 8'h44, 2'd2);
        set_vec(18, 1'b0, 4'b0000, ab_a, ab_b, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);

        @(posedge clk);
        #1;

        for (int i = 0; i <= 18; i++) begin
            if (vecs[i].rb) do_reset();
            drive_sample(vecs[i].rq, vecs[i].a, vecs[i].b, vecs[i].rdy);
            chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(vecs[i].egnt));
            chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].evalid));
            if (vecs[i].evalid) begin
                chk($sformatf("vec%0d.out", i), 32'(out), 32'(vecs[i].eout));
                chk($sformatf("vec%0d.id", i), 32'(out_id), 32'(vecs[i].eid));
            end
            advance($sformatf("vec%0d.m", i));
        end

        // Reset while a result is held: out_valid drops without waiting for a clock edge.
        do_reset();
        drive_sample(4'b0001, s1a, s1b, 1'b0);
        advance("hold.m");
        req = 4'b0000;
        chk("hold.valid_before", 32'(out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("hold.valid_async", 32'(out_valid), 32'h0);
        chk("hold.out_async", 32'(out), 32'h0);
        chk("hold.id_async", 32'(out_id), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive_sample(4'b1010, ab_a, ab_b, 1'b1);
        chk("hold.first_gnt", 32'(gnt), 32'h2);
        advance("hold.after");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive_sample(4'($urandom_range(0, 15)), $urandom(), $urandom(),
                         ($urandom_range(0, 3) != 0));
            advance("rand");
        end

`ifdef AND_ARB_CNT_EN
        do_reset();
        req = 4'hF; out_ready = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("cnt.ffff", 32'(op_count), 32'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("cnt.wrap", 32'(op_count), 32'h1);
        req = 4'h0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
